// File: rtl/fuzz_out_misr.sv
// Compacts the fuzz netlist output bus into a MISR signature over a programmed number of cycles (optional input register: FUZZ_MISR_INREG_EN).
// Latency: done rises one cycle after the last of N samples; start with N=0 goes straight to DONE.
// Backpressure: none; start is ignored while busy, and DONE holds until restart or reset.
module fuzz_out_misr #(
    parameter int                 WIDTH = 11,
    parameter int                 SIG_W = 32,
    parameter int                 CNT_W = 16,
    parameter logic [SIG_W-1:0]   POLY  = SIG_W'(32'h04C11DB7),
    parameter logic [SIG_W-1:0]   SEED  = SIG_W'(32'h00000000)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_cycles,
    input  logic [WIDTH-1:0]   dut_out,
    output logic               busy,
    output logic               done,
    output logic [SIG_W-1:0]   signature,
    output logic [CNT_W-1:0]   remaining
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   sample;
    logic [SIG_W-1:0]   sample_ext;
    logic [SIG_W-1:0]   sig_step;

`ifdef FUZZ_MISR_INREG_EN
    logic [WIDTH-1:0]   dut_q;

    // Retimes the netlist outputs so the MISR sees a clean flop-to-flop path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_q <= '0;
        end else begin
            dut_q <= dut_out;
        end
    end

    assign sample = dut_q;
`else
    assign sample = dut_out;
`endif

    always_comb begin
        sample_ext              = '0;
        sample_ext[WIDTH-1:0]   = sample;
    end

    assign sig_step = {signature[SIG_W-2:0], 1'b0}
                    ^ (signature[SIG_W-1] ? POLY : '0)
                    ^ sample_ext;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = (num_cycles != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                // remaining is never 0 in RUN, so the run ends on the last sample.
                if (remaining == CNT_W'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            signature <= SEED;
            remaining <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        signature <= SEED;
                        remaining <= num_cycles;
                    end
                end
                S_RUN: begin
                    signature <= sig_step;
                    remaining <= remaining - CNT_W'(1);
                end
                default: begin
                    signature <= SEED;
                    remaining <= '0;
                end
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule
